// File: rtl/message_build_pad.sv
// SHA-2 message builder: turns message blocks plus a per-message length into padded blocks
// (data, '1', zeros, length), with an optional extra length block and a pass-through mode.
module message_build_pad #(
    parameter int BLOCK_W = 512,
    parameter int LEN_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEN_W-1:0]   cfg_size,
    input  logic [1:0]         cfg_scheme,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic               data_in_last,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    output logic [BLOCK_W-1:0] data_out,
    output logic               data_out_last,
    output logic               data_out_valid,
    input  logic               data_out_ready,
    output logic               len_err
);

    localparam int LOG_B = $clog2(BLOCK_W);
    localparam int CNT_W = LEN_W - LOG_B + 1;
    localparam logic [LOG_B-1:0]   R_FIT_MAX = LOG_B'(BLOCK_W - LEN_W - 1);
    localparam logic [BLOCK_W-1:0] MSB_ONE   = {1'b1, {(BLOCK_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DATA, EXTRA} state_t;

    function automatic logic [BLOCK_W-1:0] size_field(input logic [LEN_W-1:0] s);
        size_field = '0;
        size_field[LEN_W-1:0] = s;
    endfunction

    // Keep the r leading message bits, clear the rest, and append the '1' marker bit.
    function automatic logic [BLOCK_W-1:0] pad_tail(input logic [BLOCK_W-1:0] d,
                                                    input logic [LOG_B-1:0]   r);
        logic [BLOCK_W-1:0] keep;
        keep = ~({BLOCK_W{1'b1}} >> r);
        pad_tail = (d & keep) | (MSB_ONE >> r);
    endfunction

    state_t             state, state_d;
    logic [LEN_W-1:0]   size_q;
    logic [1:0]         scheme_q;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   exp_beats;
    logic [LOG_B-1:0]   r;
    logic               r_nz, size_zero, pass;
    logic               out_free, cfg_fire, in_fire;
    logic               load, load_last, set_err;
    logic [BLOCK_W-1:0] load_data;
    logic [BLOCK_W-1:0] out_data_p1;
    logic               out_last_p1, vld_p1, len_err_q;

    assign r         = size_q[LOG_B-1:0];
    assign r_nz      = (r != '0);
    assign size_zero = (size_q == '0);
    assign pass      = (scheme_q == 2'd1);
    assign exp_beats = size_zero ? CNT_W'(1)
                     : {1'b0, size_q[LEN_W-1:LOG_B]} + {{(CNT_W-1){1'b0}}, r_nz};

    assign out_free      = !vld_p1 || data_out_ready;
    assign cfg_ready     = (state == IDLE);
    assign data_in_ready = (state == DATA) && out_free;
    assign cfg_fire      = cfg_valid && cfg_ready;
    assign in_fire       = data_in_valid && data_in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        load      = 1'b0;
        load_data = data_in;
        load_last = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: if (cfg_fire) state_d = DATA;
            DATA: begin
                if (in_fire) begin
                    load = 1'b1;
                    if (pass) begin
                        load_last = data_in_last;
                        if (data_in_last) state_d = IDLE;
                    end else if (data_in_last) begin
                        set_err = ((beat_cnt + CNT_W'(1)) != exp_beats);
                        if (size_zero) begin
                            load_data = MSB_ONE;
                            load_last = 1'b1;
                            state_d   = IDLE;
                        end else if (r_nz) begin
                            load_data = pad_tail(data_in, r);
                            if (r <= R_FIT_MAX) begin
                                load_data = load_data | size_field(size_q);
                                load_last = 1'b1;
                                state_d   = IDLE;
                            end else begin
                                state_d = EXTRA;
                            end
                        end else begin
                            state_d = EXTRA;
                        end
                    end
                end
            end
            EXTRA: begin
                // A block-aligned message still owes its '1' marker here.
                if (out_free) begin
                    load      = 1'b1;
                    load_data = (r_nz ? '0 : MSB_ONE) | size_field(size_q);
                    load_last = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cfg_fire) begin
            size_q   <= cfg_size;
            scheme_q <= cfg_scheme;
        end
    end

    // Stage p1: output register, beat counter and sticky length flag
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            out_data_p1 <= '0;
            out_last_p1 <= 1'b0;
            len_err_q   <= 1'b0;
            beat_cnt    <= '0;
        end else begin
            if (load) begin
                vld_p1      <= 1'b1;
                out_data_p1 <= load_data;
                out_last_p1 <= load_last;
            end else if (data_out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (cfg_fire) begin
                len_err_q <= 1'b0;
                beat_cnt  <= '0;
            end else begin
                if (in_fire) beat_cnt <= beat_cnt + CNT_W'(1);
                if (set_err) len_err_q <= 1'b1;
            end
        end
    end

    assign data_out       = out_data_p1;
    assign data_out_last  = out_last_p1;
    assign data_out_valid = vld_p1;
    assign len_err        = len_err_q;

endmodule
